i_mem_byte_ctrl: RTL

Word-access controller for one port of the byte-wide dual-port instruction memory. It arbitrates round-robin between two word requesters (requester 0: ring interface; requester 1: boot/debug loader). Each accepted 32-bit read or write is serialized into four consecutive byte accesses on the memory port, and read bytes are reassembled into a word. It sits between the ring/loader logic and port B of the instruction memory; port A stays private to the core fetch path.

---
 rtl/lotr_pkg.sv | 14 +
 rtl/rr_arb2.sv | 28 ++
 rtl/i_mem_byte_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/lotr_pkg.sv
// Shared instruction-memory constants and the byte-controller state type.
package lotr_pkg;

  localparam int MSB_I_MEM  = 11;
  localparam int SIZE_I_MEM = 1 << (MSB_I_MEM + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } t_i_mem_ctrl_st;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; last_grant flips only on an accepted grant.
module rr_arb2 (
  input  logic clock,
  input  logic rst,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_accept,
  output logic o_grant0,
  output logic o_grant1
);

  logic r_last_grant;

  // On a tie, the requester that was not granted last wins.
  always_comb begin
    o_grant0 = i_valid0 && (!i_valid1 || r_last_grant);
    o_grant1 = i_valid1 && !o_grant0;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (i_accept) begin
      r_last_grant <= o_grant1;
    end
  end

endmodule

// File: rtl/i_mem_byte_ctrl.sv
// Serializes arbitrated 32-bit word reads/writes into four byte accesses on
// instruction-memory port B and reassembles read bytes into a word.
//
//   state  | meaning
//   IDLE   | arbitrate, accept at most one request
//   ACCESS | four byte cycles, k = 0..3
//   DRAIN  | reads only: capture the last registered byte
//   RESP   | one-cycle completion pulse to the latched requester
module i_mem_byte_ctrl
  import lotr_pkg::*;
#(
  parameter int MEM_MSB = MSB_I_MEM
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_wr,
  input  logic [MEM_MSB:0]   req0_addr,
  input  logic [31:0]        req0_wdata,
  input  logic [3:0]         req0_be,
  output logic               rsp0_valid,
  output logic [31:0]        rsp0_rdata,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_wr,
  input  logic [MEM_MSB:0]   req1_addr,
  input  logic [31:0]        req1_wdata,
  input  logic [3:0]         req1_be,
  output logic               rsp1_valid,
  output logic [31:0]        rsp1_rdata,
  output logic [MEM_MSB:0]   mem_address,
  output logic [7:0]         mem_data,
  output logic               mem_rden,
  output logic               mem_wren,
  input  logic [7:0]         mem_q,
  output logic               busy
);

  t_i_mem_ctrl_st r_state;
  t_i_mem_ctrl_st w_next;

  logic [MEM_MSB:2] r_addr;
  logic             r_wr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_be;
  logic             r_id;
  logic [1:0]       r_k;
  logic [31:0]      r_rdata;
  logic             r_cap_vld;
  logic [1:0]       r_cap_k;

  logic       w_grant0;
  logic       w_grant1;
  logic       w_idle;
  logic       w_accept;
  logic [4:0] w_bsel;
  logic [4:0] w_cap_sel;
  logic       w_unused;

  assign w_unused  = ^{req0_addr[1:0], req1_addr[1:0]};
  assign w_idle    = (r_state == IDLE) && !rst;
  assign w_accept  = w_idle && (w_grant0 || w_grant1);
  assign w_bsel    = {r_k, 3'b000};
  assign w_cap_sel = {r_cap_k, 3'b000};

  rr_arb2 u_arb (
    .clock    (clock),
    .rst      (rst),
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .i_accept (w_accept),
    .o_grant0 (w_grant0),
    .o_grant1 (w_grant1)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = ACCESS;
      ACCESS:  if (r_k == 2'd3) w_next = r_wr ? RESP : DRAIN;
      DRAIN:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bytes come back one cycle after their access, so capture lags k by one.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_id      <= 1'b0;
      r_k       <= '0;
      r_rdata   <= '0;
      r_cap_vld <= 1'b0;
      r_cap_k   <= '0;
    end else begin
      r_cap_vld <= (r_state == ACCESS) && !r_wr;
      r_cap_k   <= r_k;
      if (w_accept) begin
        r_id    <= w_grant1;
        r_addr  <= w_grant1 ? req1_addr[MEM_MSB:2] : req0_addr[MEM_MSB:2];
        r_wr    <= w_grant1 ? req1_wr    : req0_wr;
        r_wdata <= w_grant1 ? req1_wdata : req0_wdata;
        r_be    <= w_grant1 ? req1_be    : req0_be;
        r_k     <= '0;
        r_rdata <= '0;
      end
      if (r_state == ACCESS) begin
        r_k <= r_k + 2'd1;
      end
      if (r_cap_vld) begin
        r_rdata[w_cap_sel +: 8] <= mem_q;
      end
    end
  end

  always_comb begin
    req0_ready  = w_idle && w_grant0;
    req1_ready  = w_idle && w_grant1;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    rsp0_rdata  = '0;
    rsp1_rdata  = '0;
    mem_address = '0;
    mem_data    = '0;
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    busy        = (r_state != IDLE);
    case (r_state)
      ACCESS: begin
        mem_address = {r_addr, r_k};
        mem_rden    = !r_wr;
        mem_wren    = r_wr && r_be[r_k];
        mem_data    = r_wr ? r_wdata[w_bsel +: 8] : 8'h00;
      end
      RESP: begin
        if (r_id) begin
          rsp1_valid = 1'b1;
          rsp1_rdata = r_wr ? 32'h0 : r_rdata;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_rdata = r_wr ? 32'h0 : r_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule
